// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA scan path.
//   - 640x480@60 timing constants and the derived H_TOTAL / V_TOTAL
//   - rgb444 pixel type and a small palette of 12-bit colour constants
package vga_pkg;

  typedef logic [11:0] rgb444;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;  // 800
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;  // 525

  localparam rgb444 RED    = 12'hF00;
  localparam rgb444 GREEN  = 12'h0F0;
  localparam rgb444 BLUE   = 12'h00F;
  localparam rgb444 WHITE  = 12'hFFF;
  localparam rgb444 BLACK  = 12'h000;
  localparam rgb444 YELLOW = 12'hFF0;
  localparam rgb444 CYAN   = 12'h0FF;
  localparam rgb444 ROYAL  = 12'h46E;

endpackage

// File: rtl/vga_pix_ce.sv
// vga_pix_ce: divides the system clock into a one-clk pixel enable.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   pix_ce out  high for one clk out of every CLK_DIV (CLK_DIV >= 2)
module vga_pix_ce #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_ce
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_MAX) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // Combinational so the first enable is consumed on the CLK_DIV-th edge
  // after reset release.
  assign pix_ce = (div_cnt == DIV_MAX);

endmodule

// File: rtl/vga_scan_driver.sv
// vga_scan_driver: scan-side VGA driver. Generates the scan position for the
// drawing modules, registers their returned RGB444 pixel against one-pixel
// delayed sync/blanking and drives the VGA pins.
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   VGA_xpos, VGA_ypos  published scan position (raw counters, not gated)
//   VGA_data            RGB444 pixel for the published position
//   VGA_r/g/b           registered pin colours (black outside the active area)
//   VGA_HS, VGA_VS      registered active-low syncs
//   frame_start         one-clk pulse when the scan wraps to (0,0)
// Build option: define VGA_BORDER_EN to force a white 1-pixel frame around
// the active area as a screen-alignment aid.
module vga_scan_driver
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [10:0] VGA_xpos,
  output logic [10:0] VGA_ypos,
  input  logic [11:0] VGA_data,
  output logic [3:0]  VGA_r,
  output logic [3:0]  VGA_g,
  output logic [3:0]  VGA_b,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic        pix_ce;
  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic        active;
  logic        hs_n;
  logic        vs_n;
  logic        line_end;
  rgb444       pix;

  vga_pix_ce #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_ce (
    .clk    (clk),
    .rst_n  (rst_n),
    .pix_ce (pix_ce)
  );

  assign line_end = (h_cnt == H_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_ce) begin
      if (line_end) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
      end else begin
        h_cnt <= h_cnt + 11'd1;
      end
    end
  end

  assign VGA_xpos = h_cnt;
  assign VGA_ypos = v_cnt;

  assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_n   = !((h_cnt >= HS_BEG) && (h_cnt <= HS_END));
  assign vs_n   = !((v_cnt >= VS_BEG) && (v_cnt <= VS_END));

`ifdef VGA_BORDER_EN
  localparam logic [10:0] H_ACT_LAST = 11'(H_ACTIVE - 1);
  localparam logic [10:0] V_ACT_LAST = 11'(V_ACTIVE - 1);
  logic border;
  assign border = (h_cnt == 11'd0) || (h_cnt == H_ACT_LAST) ||
                  (v_cnt == 11'd0) || (v_cnt == V_ACT_LAST);
  assign pix = !active ? BLACK : (border ? WHITE : VGA_data);
`else
  assign pix = active ? VGA_data : BLACK;
`endif

  // Output stage samples the pre-advance counters, so sync, blank and RGB
  // all carry the same one-pixel delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      VGA_HS              <= 1'b1;
      VGA_VS              <= 1'b1;
      {VGA_r, VGA_g, VGA_b} <= BLACK;
      frame_start         <= 1'b0;
    end else begin
      frame_start <= pix_ce && line_end && (v_cnt == V_LAST);
      if (pix_ce) begin
        VGA_HS              <= hs_n;
        VGA_VS              <= vs_n;
        {VGA_r, VGA_g, VGA_b} <= pix;
      end
    end
  end

endmodule

// File: doc/vga_scan_driver.md
# vga_scan_driver

Scan-side VGA driver for the 640x480@60 display path. It divides the system clock into a pixel tick and runs horizontal and vertical scan counters. It publishes the current scan position as VGA_xpos/VGA_ypos to the drawing modules, which return 12-bit RGB444 pixel data. The block registers that returned data against delayed sync and blanking, and drives the physical VGA pins.

## Interface

Parameters:
- CLK_DIV, 4: system clocks per pixel; must be >= 2.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: reset; one clock domain, asynchronous assert, active-low.
- VGA_xpos, out, 11: current horizontal count, 0..H_TOTAL-1.
- VGA_ypos, out, 11: current vertical count, 0..V_TOTAL-1.
- VGA_data, in, 12: RGB444 pixel returned by the drawing modules for the published position.
- VGA_r, VGA_g, VGA_b, out, 4 each: pin colour outputs.
- VGA_HS, out, 1: horizontal sync, active-low.
- VGA_VS, out, 1: vertical sync, active-low.
- frame_start, out, 1: one-clk pulse at the start of each frame.

## Operation

- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800. V_TOTAL = 525.
- Divider:
  - div_cnt runs 0..CLK_DIV-1 and wraps.
  - pix_ce is high for one clk when div_cnt == CLK_DIV-1.
- Scan counters (registered, advance only on pix_ce):
  - h_cnt counts 0..H_TOTAL-1, then wraps to 0.
  - v_cnt increments when h_cnt wraps, and itself wraps at V_TOTAL-1.
  - Count 0 is the first visible pixel/line.
- VGA_xpos = h_cnt and VGA_ypos = v_cnt, driven directly from the registers with no gating in blanking.
- active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- hs_n is low when h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751.
- vs_n is low when v_cnt is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491.
- Output stage, on pix_ce:
  - VGA_HS <= hs_n.
  - VGA_VS <= vs_n.
  - {VGA_r,VGA_g,VGA_b} <= active ? VGA_data : 12'h000.
  - All three use the pre-advance counter values.
- Drawing modules must present valid VGA_data within CLK_DIV-1 clks of a counter change. A one-clk registered consumer meets this.
- frame_start pulses for the clk in which the counters transition to (0,0).
- Reset values:
  - div_cnt, h_cnt, v_cnt, VGA_xpos, VGA_ypos = 0.
  - VGA_HS = VGA_VS = 1.
  - RGB = 0.
  - frame_start = 0.
- Reset mid-frame: all of the above return to reset values immediately. After release, scanning restarts at (0,0) with no partial-frame recovery. frame_start does not pulse for that restart.
- Out-of-range VGA_data during blanking is ignored.

## Timing

- First pix_ce: the CLK_DIV-th rising edge after rst_n deasserts.
- Counter update: one clk after pix_ce. VGA_xpos/VGA_ypos are stable for CLK_DIV clks.
- Pixel latency: the position published after tick N appears on the RGB pins in the clk following tick N+1. Latency is one pixel period plus one clk.
- HS and VS carry the same one-pixel delay as RGB, so sync/blank/RGB stay mutually aligned.
- Line period: 800 ticks = 3200 clks at CLK_DIV=4. HS low for 96 ticks.
- Frame period: 525 lines. VS low for 2 lines (1600 ticks).

## Configuration

- VGA_BORDER_EN defined: active pixels with x==0, x==H_ACTIVE-1, y==0 or y==V_ACTIVE-1 drive 12'hFFF, overriding VGA_data. This is a screen-alignment aid.
- VGA_BORDER_EN undefined: no override; all active pixels come from VGA_data.

## Structure

- Shared package vga_pkg:
  - 640x480 timing constants and derived H_TOTAL/V_TOTAL.
  - 12-bit colour constants RED, GREEN, BLUE, WHITE, BLACK, YELLOW, CYAN, ROYAL.
  - An rgb444 typedef.
- One sub-module, vga_pix_ce: the parameterised CLK_DIV divider producing pix_ce.
- Counters, sync decode and the output register stay in vga_scan_driver.

## Test plan

- Reset: hold rst_n=0 for 10 clks, release.
  - During reset: HS=VS=1, RGB=0, xpos=ypos=0.
  - First pix_ce on the 4th edge after release.
- Horizontal timing: run one line.
  - VGA_HS falls 657 ticks after line start (656 + 1 pipeline), stays low 384 clks.
  - Line period is exactly 3200 clks.
- Vertical timing: run a full frame.
  - VGA_VS is low for exactly 1600 ticks.
  - frame_start pulses once per 420000 ticks (525 lines x 800).
- Data path: drive VGA_data=12'h00F when xpos==5, otherwise 12'hF00.
  - Blue appears on the pins one pixel after the xpos==5 tick.
  - RGB is 0 throughout h_cnt >= 640.
- Border: with VGA_BORDER_EN defined and VGA_data=12'h000, pixels (0,0), (639,10) and (10,479) output 12'hFFF and (10,10) outputs 0. Without the macro, all four output 0.
- Reset mid-frame: assert rst_n at (300,200) for 3 clks.
  - Outputs return to reset values immediately.
  - Scanning restarts at (0,0); no frame_start pulse on that restart.
